// File: rtl/spi_dac_pkg.sv
// rtl/spi_dac_pkg.sv - shared types and defaults for the DAC SPI receiver
package spi_dac_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_t;

  localparam int DEF_DATA_W  = 12;
  localparam int DEF_LEAD    = 1;
  localparam int DEF_TRAIL   = 1;
  localparam int FRAME_EDGES = DEF_LEAD + DEF_DATA_W + DEF_TRAIL;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-flop synchronizer with history flop for edge detection
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      hist <= RST_VAL;
    end else begin
      s1   <= din;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~hist;
  assign fall = ~s2 & hist;

endmodule

// File: rtl/spi_dac_rx.sv
// rtl/spi_dac_rx.sv - SPI slave receiver that recovers words sent by the DAC SPI master
module spi_dac_rx
  import spi_dac_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LEAD      = DEF_LEAD,
  parameter int TRAIL     = DEF_TRAIL,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam logic [CNT_W-1:0] LEAD_C   = CNT_W'(LEAD);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(LEAD + DATA_W - 1);
  localparam logic [CNT_W-1:0] FRAME_C  = CNT_W'(LEAD + DATA_W + TRAIL);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  logic cs_sync, cs_rise, cs_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_s1, mosi_s;
  logic sync_unused;

  rx_state_t         state;
  logic [DATA_W-1:0] sh;
  logic [CNT_W-1:0]  edge_cnt;

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (cs),
    .sync (cs_sync),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sclk),
    .sync (sclk_sync),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  assign sync_unused = ^{cs_sync, sclk_sync, sclk_rise};

  // mosi shares the sclk sync delay so data stays aligned with the detected fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_s1 <= 1'b0;
      mosi_s  <= 1'b0;
    end else begin
      mosi_s1 <= mosi;
      mosi_s  <= mosi_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sh         <= '0;
      edge_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            sh       <= '0;
            edge_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_RECV;
          end
        end
        ST_RECV: begin
          // close takes priority over a coincident sclk fall
          if (cs_rise) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
            if (edge_cnt == FRAME_C) begin
              dout       <= sh;
              dout_valid <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else if (sclk_fall) begin
            if (edge_cnt != CNT_SAT)
              edge_cnt <= edge_cnt + CNT_W'(1);
            if (edge_cnt >= LEAD_C && edge_cnt <= LAST_C) begin
              if (LSB_FIRST)
                sh <= {mosi_s, sh[DATA_W-1:1]};
              else
                sh <= {sh[DATA_W-2:0], mosi_s};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
